bios_boot_loader: RTL and testbench
===================================

// Module: bios_boot_loader
// PURPOSE
//  Parametrised boot sequencer for the i281 CPU. After reset it copies a BIOS image,
//  read word-by-word from an external hardcoded ROM block, into instruction memory
//  through a write port with ack handshake. It then checks an additive checksum and
//  releases the CPU from hold. It supports reload on request and an ack timeout.
// PARAMETERS
//  WIDTH       16      instruction word width (bits)
//  DEPTH       16      number of words in the BIOS image (>=1)
//  ADDR_W      5       address width of rom_addr / wr_addr (2**ADDR_W >= BASE_ADDR+DEPTH)
//  BASE_ADDR   0       instruction-memory address receiving image word 0
//  WAIT_ACK    1       1: each write holds until wr_ack; 0: one write per cycle, wr_ack ignored
//  ACK_TIMEOUT 15      max cycles a write may wait for wr_ack before FAIL (WAIT_ACK=1 only)
//  CHECK_EN    1       1: compare checksum against EXPECT_SUM; 0: always pass
//  EXPECT_SUM  0       expected sum of all image words, modulo 2**WIDTH
// PORTS
//  clock      in   1       system clock, rising edge
//  reset_n    in   1       asynchronous active-low reset
//  start      in   1       reload request; honoured only in DONE or FAIL
//  rom_addr   out  ADDR_W  image word index (0..DEPTH-1) to the ROM block
//  rom_data   in   WIDTH   combinational ROM word for rom_addr
//  wr_en      out  1       instruction-memory write strobe
//  wr_addr    out  ADDR_W  BASE_ADDR + index
//  wr_data    out  WIDTH   equals rom_data while wr_en=1
//  wr_ack     in   1       memory accepted current write (sampled while wr_en=1)
//  cpu_hold   out  1       1 holds the CPU in reset/stall
//  done       out  1       image loaded and verified
//  err        out  1       checksum mismatch or ack timeout
//  busy       out  1       state is COPY or CHECK
// BEHAVIOUR
//  - States: IDLE, COPY, CHECK, DONE, FAIL. Registers: idx, sum, wait_cnt.
//  - Reset (async): state=IDLE, idx=0, sum=0, wait_cnt=0. Outputs: cpu_hold=1,
//    wr_en=0, done=0, err=0, busy=0.
//  - IDLE: on the next edge, go to COPY with idx=0, sum=0, wait_cnt=0.
//  - COPY: wr_en=1; rom_addr=idx; wr_addr=BASE_ADDR+idx; wr_data=rom_data (all combinational).
//  - Accept = wr_en & (wr_ack | ~WAIT_ACK). On accept: sum<=sum+rom_data (mod 2**WIDTH),
//    wait_cnt<=0. If idx==DEPTH-1, go to CHECK; else idx<=idx+1.
//  - No accept with WAIT_ACK=1: wait_cnt++. When wait_cnt==ACK_TIMEOUT, go to FAIL
//    without writing further. An ack in the same cycle as the timeout wins (the write is accepted).
//  - CHECK: one cycle, wr_en=0. If CHECK_EN=0 or sum==EXPECT_SUM, go to DONE; else go to FAIL.
//  - DONE: cpu_hold=0, done=1. FAIL: cpu_hold=1, err=1. Both are sticky until start or reset.
//  - start=1 in DONE/FAIL goes to IDLE (cpu_hold=1, done=0, err=0 next cycle) and the
//    copy reruns. start in IDLE/COPY/CHECK is ignored.
//  - Latency, WAIT_ACK=0: first write 1 cycle after reset release. DEPTH writes on
//    consecutive cycles, then 1 CHECK cycle. done rises DEPTH+2 cycles after release.
//  - rom_addr holds the last idx outside COPY. wr_addr/wr_data are don't-care when wr_en=0.
//  - Reset mid-COPY aborts immediately: wr_en drops asynchronously and the copy restarts from idx 0.
// TESTING
//  1 DEPTH=4, ROM {1,2,3,4}, EXPECT_SUM=10, WAIT_ACK=0 -> wr_addr 0,1,2,3 on cycles
//    1-4 after release, done=1 and cpu_hold=0 at cycle 6, err=0.
//  2 Same image, WAIT_ACK=1, ack after 3 cycles per word -> each word held 4 cycles,
//    wr_data stable while waiting, done at cycle 18.
//  3 EXPECT_SUM=11 -> FAIL: err=1, cpu_hold=1, done=0. Then pulse start with EXPECT_SUM
//    fixed via a second instance -> both reload; the corrected instance reaches DONE.
//  4 ACK_TIMEOUT=15, wr_ack tied 0 -> word 0 held 15 cycles, then err=1, wr_en=0, no index advance.
//  5 BASE_ADDR=8, ROM {FFFF,0001}, EXPECT_SUM=0 -> writes to 8,9, sum wraps to 0, done=1.
//  6 reset_n low during idx=2 of COPY -> wr_en=0 at once. After release, rewrite
//    starts at wr_addr=BASE_ADDR and completes normally. start in COPY has no effect.

Source files
------------

// File: rtl/bios_boot_loader.sv
// Boot sequencer: copies a BIOS image from a combinational ROM into instruction
// memory, verifies an additive checksum, then releases the CPU from hold.
module bios_boot_loader #(
    parameter int               WIDTH       = 16,
    parameter int               DEPTH       = 16,
    parameter int               ADDR_W      = 5,
    parameter int               BASE_ADDR   = 0,
    parameter int               WAIT_ACK    = 1,
    parameter int               ACK_TIMEOUT = 15,
    parameter int               CHECK_EN    = 1,
    parameter logic [WIDTH-1:0] EXPECT_SUM  = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WIDTH-1:0]  rom_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data,
    input  logic              wr_ack,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic              busy
);
    localparam int                CNT_W    = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    // The no-ack cycle that brings wait_cnt up to ACK_TIMEOUT is also the one that aborts.
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((ACK_TIMEOUT < 1) ? 0 : ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COPY,
        S_CHECK,
        S_DONE,
        S_FAIL
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] idx, idx_next;
    logic [WIDTH-1:0]  sum, sum_next;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_next;
    logic              accept;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            sum      <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            sum      <= sum_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        idx_next      = idx;
        sum_next      = sum;
        wait_cnt_next = wait_cnt;
        // Outputs decode straight from the state register so a reset drops wr_en at once.
        wr_en         = (state == S_COPY);
        accept        = wr_en && (wr_ack || (WAIT_ACK == 0));
        rom_addr      = idx;
        wr_addr       = idx + BASE;
        wr_data       = rom_data;
        cpu_hold      = (state != S_DONE);
        done          = (state == S_DONE);
        err           = (state == S_FAIL);
        busy          = (state == S_COPY) || (state == S_CHECK);

        case (state)
            S_IDLE: begin
                state_next    = S_COPY;
                idx_next      = '0;
                sum_next      = '0;
                wait_cnt_next = '0;
            end
            S_COPY: begin
                if (accept) begin
                    sum_next      = sum + rom_data;
                    wait_cnt_next = '0;
                    if (idx == LAST_IDX) begin
                        state_next = S_CHECK;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                    if (wait_cnt >= CNT_LAST) begin
                        state_next = S_FAIL;
                    end
                end
            end
            S_CHECK: begin
                if ((CHECK_EN == 0) || (sum == EXPECT_SUM)) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_FAIL;
                end
            end
            S_DONE, S_FAIL: begin
                if (start) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_bios_boot_loader.sv
// Directed bench: five boot loader instances covering no-wait copy, ack-wait copy,
// checksum failure with reload, ack timeout, offset base with wrapping sum, and mid-copy reset.
module tb_bios_boot_loader;
    logic clock;
    logic reset_n;
    logic reset_a_n;
    logic start_ac;
    logic start_off;
    logic ack_b;
    logic ack_off;
    int   tests;
    int   fails;
    int   cyc;

    logic [4:0]  rom_addr_a, rom_addr_b, rom_addr_c, rom_addr_d, rom_addr_e;
    logic [15:0] rom_data_a, rom_data_b, rom_data_c, rom_data_d, rom_data_e;
    logic        wr_en_a, wr_en_b, wr_en_c, wr_en_d, wr_en_e;
    logic [4:0]  wr_addr_a, wr_addr_b, wr_addr_c, wr_addr_d, wr_addr_e;
    logic [15:0] wr_data_a, wr_data_b, wr_data_c, wr_data_d, wr_data_e;
    logic        hold_a, hold_b, hold_c, hold_d, hold_e;
    logic        done_a, done_b, done_c, done_d, done_e;
    logic        err_a, err_b, err_c, err_d, err_e;
    logic        busy_a, busy_b, busy_c, busy_d, busy_e;

    // Image {1,2,3,4} and image {FFFF,0001}
    function automatic logic [15:0] img4(input logic [4:0] a);
        return 16'(a[1:0]) + 16'd1;
    endfunction
    function automatic logic [15:0] img2(input logic [4:0] a);
        return a[0] ? 16'h0001 : 16'hFFFF;
    endfunction

    assign rom_data_a = img4(rom_addr_a);
    assign rom_data_b = img4(rom_addr_b);
    assign rom_data_c = img4(rom_addr_c);
    assign rom_data_d = img4(rom_addr_d);
    assign rom_data_e = img2(rom_addr_e);

    bios_boot_loader #(.DEPTH(4), .WAIT_ACK(0), .EXPECT_SUM(16'd10)) u_a (
        .clock(clock), .reset_n(reset_a_n), .start(start_ac),
        .rom_addr(rom_addr_a), .rom_data(rom_data_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .wr_ack(ack_off), .cpu_hold(hold_a), .done(done_a),
        .err(err_a), .busy(busy_a));

    bios_boot_loader #(.DEPTH(4), .WAIT_ACK(1), .EXPECT_SUM(16'd10)) u_b (
        .clock(clock), .reset_n(reset_n), .start(start_off),
        .rom_addr(rom_addr_b), .rom_data(rom_data_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .wr_ack(ack_b), .cpu_hold(hold_b), .done(done_b),
        .err(err_b), .busy(busy_b));

    bios_boot_loader #(.DEPTH(4), .WAIT_ACK(0), .EXPECT_SUM(16'd11)) u_c (
        .clock(clock), .reset_n(reset_n), .start(start_ac),
        .rom_addr(rom_addr_c), .rom_data(rom_data_c), .wr_en(wr_en_c), .wr_addr(wr_addr_c),
        .wr_data(wr_data_c), .wr_ack(ack_off), .cpu_hold(hold_c), .done(done_c),
        .err(err_c), .busy(busy_c));

    bios_boot_loader #(.DEPTH(4), .WAIT_ACK(1), .ACK_TIMEOUT(15), .EXPECT_SUM(16'd10)) u_d (
        .clock(clock), .reset_n(reset_n), .start(start_off),
        .rom_addr(rom_addr_d), .rom_data(rom_data_d), .wr_en(wr_en_d), .wr_addr(wr_addr_d),
        .wr_data(wr_data_d), .wr_ack(ack_off), .cpu_hold(hold_d), .done(done_d),
        .err(err_d), .busy(busy_d));

    bios_boot_loader #(.DEPTH(2), .BASE_ADDR(8), .WAIT_ACK(0), .EXPECT_SUM(16'd0)) u_e (
        .clock(clock), .reset_n(reset_n), .start(start_off),
        .rom_addr(rom_addr_e), .rom_data(rom_data_e), .wr_en(wr_en_e), .wr_addr(wr_addr_e),
        .wr_data(wr_data_e), .wr_ack(ack_off), .cpu_hold(hold_e), .done(done_e),
        .err(err_e), .busy(busy_e));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Expectations for u_a over one boot counted from reset release
    task automatic chk_a_boot(input int c);
        chk("a_wr_en", wr_en_a, c <= 4);
        if (c <= 4) begin
            chk("a_wr_addr", wr_addr_a, c - 1);
            chk("a_wr_data", wr_data_a, c);
        end
        chk("a_busy", busy_a, c <= 5);
        chk("a_done", done_a, c >= 6);
        chk("a_hold", cpu_hold_exp(c >= 6), hold_a);
        chk("a_err", err_a, 0);
    endtask

    function automatic logic cpu_hold_exp(input logic is_done);
        return ~is_done;
    endfunction

    initial begin
        tests     = 0;
        fails     = 0;
        cyc       = 0;
        reset_n   = 1'b0;
        reset_a_n = 1'b0;
        start_ac  = 1'b0;
        start_off = 1'b0;
        ack_b     = 1'b0;
        ack_off   = 1'b0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_wr_en", wr_en_a, 0);
        chk("rst_hold", hold_a, 1);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_busy", busy_a, 0);
        reset_n   = 1'b1;
        reset_a_n = 1'b1;
        #1;
        chk("idle_rom_addr", rom_addr_a, 0);
        chk("idle_wr_en", wr_en_b, 0);

        // Phase 1: all five instances boot from the same release
        for (int i = 1; i <= 20; i++) begin
            tick();
            ack_b = (cyc % 4 == 0) && (cyc <= 16);
            @(negedge clock);
            chk_a_boot(cyc);
            chk("b_wr_en", wr_en_b, cyc <= 16);
            if (cyc <= 16) begin
                chk("b_wr_addr", wr_addr_b, (cyc - 1) / 4);
                chk("b_wr_data", wr_data_b, (cyc - 1) / 4 + 1);
            end
            chk("b_busy", busy_b, cyc <= 17);
            chk("b_done", done_b, cyc >= 18);
            chk("b_hold", hold_b, cyc < 18);
            chk("c_err", err_c, cyc >= 6);
            chk("c_done", done_c, 0);
            chk("c_hold", hold_c, 1);
            chk("d_wr_en", wr_en_d, cyc <= 15);
            chk("d_rom_addr", rom_addr_d, 0);
            chk("d_err", err_d, cyc >= 16);
            chk("d_done", done_d, 0);
            chk("e_wr_en", wr_en_e, cyc <= 2);
            if (cyc <= 2) begin
                chk("e_wr_addr", wr_addr_e, 7 + cyc);
                chk("e_wr_data", wr_data_e, (cyc == 1) ? 32'hFFFF : 32'h0001);
            end
            chk("e_done", done_e, cyc >= 4);
            chk("e_err", err_e, 0);
        end

        // Phase 2: reload u_a (DONE) and u_c (FAIL); second start lands mid-copy
        for (int i = 21; i <= 30; i++) begin
            tick();
            start_ac = (cyc == 21) || (cyc == 24);
            @(negedge clock);
            if (cyc == 22) begin
                chk("re_a_hold", hold_a, 1);
                chk("re_a_done", done_a, 0);
                chk("re_c_err", err_c, 0);
                chk("re_a_wr_en", wr_en_a, 0);
            end
            if (cyc >= 23 && cyc <= 26) begin
                chk("re_a_wr_addr", wr_addr_a, cyc - 23);
                chk("re_c_wr_data", wr_data_c, cyc - 22);
            end
            chk("re_a_wr_en", wr_en_a, cyc >= 23 && cyc <= 26);
            chk("re_a_done", done_a, cyc == 21 || cyc >= 28);
            chk("re_c_err", err_c, cyc == 21 || cyc >= 28);
            chk("re_c_done", done_c, 0);
        end

        // Phase 3: reset u_a while idx=2 is being written
        for (int i = 31; i <= 35; i++) begin
            tick();
            start_ac = (cyc == 31);
        end
        @(negedge clock);
        chk("mid_wr_en", wr_en_a, 1);
        chk("mid_wr_addr", wr_addr_a, 2);
        #1 reset_a_n = 1'b0;
        #1;
        chk("abort_wr_en", wr_en_a, 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_rom_addr", rom_addr_a, 0);
        @(posedge clock);
        @(negedge clock);
        reset_a_n = 1'b1;
        cyc = 0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            @(negedge clock);
            chk_a_boot(cyc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
